shared_bus_rr_arbiter: RTL

//  NUM_DEV-device shared bus; successor to the 2-device select-driven bus mux.

---
 rtl/shared_bus_rr_arbiter_pkg.sv | 21 ++
 rtl/shared_bus_rr_arbiter_rr.sv | 41 ++++
 rtl/shared_bus_rr_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/shared_bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin shared-bus arbiter: the bus ownership
// state encoding, the id-width helper and the parameter legality check.
package shared_bus_rr_arbiter_pkg;

  // The bus is either free (no grant) or owned by exactly one device.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } bus_state_t;

  // Bits needed to hold an index 0..n-1; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A grant must allow at least one beat before it can be taken away.
  function automatic bit max_hold_legal(input int max_hold);
    return max_hold >= 1;
  endfunction

endpackage

// File: rtl/shared_bus_rr_arbiter_rr.sv
// Combinational circular-priority picker. Starting one past the last owner,
// it returns the first device whose request survives the mask, as a one-hot
// vector and as an index.
module rr_arbiter
  import shared_bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int IDW     = idw(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [NUM_DEV-1:0] mask,
  input  logic [IDW-1:0]     last_owner,
  output logic [NUM_DEV-1:0] grant_next,
  output logic [IDW-1:0]     id,
  output logic               any
);

  logic [NUM_DEV-1:0] cand;
  int                 idx;

  // Walk the devices in circular order after the last owner; the first hit wins.
  always_comb begin
    cand       = req & mask;
    grant_next = '0;
    id         = '0;
    any        = 1'b0;
    idx        = 0;
    for (int i = 1; i <= NUM_DEV; i++) begin
      idx = int'(last_owner) + i;
      if (idx >= NUM_DEV) begin
        idx = idx - NUM_DEV;
      end
      if (!any && cand[idx]) begin
        any             = 1'b1;
        grant_next[idx] = 1'b1;
        id              = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_bus_rr_arbiter.sv
// NUM_DEV-device shared bus with a round-robin request/grant arbiter and a
// bounded hold window. Grant is registered; the owner's data is registered
// onto the bus one cycle later, and every other device latches that beat into
// its read-back register the cycle after that.
module shared_bus_rr_arbiter
  import shared_bus_rr_arbiter_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_DEV  = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = idw(NUM_DEV)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DEV-1:0]       req,
  input  logic [NUM_DEV*WIDTH-1:0] data_in,
  output logic [NUM_DEV-1:0]       grant,
  output logic [WIDTH-1:0]         bus,
  output logic                     bus_valid,
  output logic [IDW-1:0]           bus_src,
  output logic [NUM_DEV*WIDTH-1:0] data_out
);

  localparam int              HOLD_W    = idw(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  if (!max_hold_legal(MAX_HOLD) || NUM_DEV < 2) begin : g_bad_params
    $error("shared_bus_rr_arbiter: need MAX_HOLD >= 1 and NUM_DEV >= 2");
  end

  // Arbitration state (stage 0)
  bus_state_t          state_p0;
  logic [NUM_DEV-1:0]  grant_p0;
  logic [HOLD_W-1:0]   hold_cnt_p0;
  logic [IDW-1:0]      last_owner_p0;

  bus_state_t          state_next;
  logic [NUM_DEV-1:0]  grant_next;
  logic [HOLD_W-1:0]   hold_cnt_next;
  logic [IDW-1:0]      last_owner_next;

  // Bus output registers (stage 1)
  logic [WIDTH-1:0]    bus_p1;
  logic                vld_p1;
  logic [IDW-1:0]      bus_src_p1;

  logic [WIDTH-1:0]    bus_next;
  logic                vld_next;
  logic [IDW-1:0]      bus_src_next;

  // Picker interface
  logic [NUM_DEV-1:0]  pick_mask;
  logic [NUM_DEV-1:0]  pick_onehot;
  logic [IDW-1:0]      pick_id;
  logic                pick_any;

  logic                owner_req;
  logic [WIDTH-1:0]    bus_sel;

  // The current owner is still asserting its request (a beat this cycle).
  assign owner_req = |(req & grant_p0);

  // While a device owns the bus, only the others are candidates for the next
  // grant; when the owner drops its request it is already absent from req.
  assign pick_mask = (state_p0 == ST_OWN) ? ~grant_p0 : {NUM_DEV{1'b1}};

  rr_arbiter #(
    .NUM_DEV (NUM_DEV),
    .IDW     (IDW)
  ) u_rr (
    .req        (req),
    .mask       (pick_mask),
    .last_owner (last_owner_p0),
    .grant_next (pick_onehot),
    .id         (pick_id),
    .any        (pick_any)
  );

  // State register: grant, hold window counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0      <= ST_IDLE;
      grant_p0      <= '0;
      hold_cnt_p0   <= '0;
      last_owner_p0 <= IDW'(NUM_DEV - 1);
    end else begin
      state_p0      <= state_next;
      grant_p0      <= grant_next;
      hold_cnt_p0   <= hold_cnt_next;
      last_owner_p0 <= last_owner_next;
    end
  end

  // Next-state: grant from idle, rotate on a full window or a dropped request.
  always_comb begin
    state_next      = state_p0;
    grant_next      = grant_p0;
    hold_cnt_next   = hold_cnt_p0;
    last_owner_next = last_owner_p0;
    case (state_p0)
      ST_IDLE: begin
        if (pick_any) begin
          state_next      = ST_OWN;
          grant_next      = pick_onehot;
          hold_cnt_next   = '0;
          last_owner_next = pick_id;
        end
      end
      ST_OWN: begin
        if (owner_req) begin
          if (hold_cnt_p0 != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_p0 + HOLD_W'(1);
          end else begin
            // Window exhausted: hand over if anyone else waits, else restart it.
            hold_cnt_next = '0;
            if (pick_any) begin
              grant_next      = pick_onehot;
              last_owner_next = pick_id;
            end
          end
        end else begin
          // Owner is done: pass straight to the next requester, or go idle.
          hold_cnt_next = '0;
          if (pick_any) begin
            grant_next      = pick_onehot;
            last_owner_next = pick_id;
          end else begin
            state_next = ST_IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Output decode: AND-OR mux of the owner's data onto the bus.
  always_comb begin
    bus_sel = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      bus_sel = bus_sel | (data_in[k*WIDTH +: WIDTH] & {WIDTH{grant_p0[k]}});
    end
    bus_next     = bus_p1;
    bus_src_next = bus_src_p1;
    vld_next     = 1'b0;
    if (state_p0 == ST_OWN) begin
      bus_next     = bus_sel;
      bus_src_next = last_owner_p0;
      vld_next     = owner_req;
    end
  end

  // Stage 0 -> stage 1: register the bus beat, its source and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_p1     <= '0;
      vld_p1     <= 1'b0;
      bus_src_p1 <= '0;
    end else begin
      bus_p1     <= bus_next;
      vld_p1     <= vld_next;
      bus_src_p1 <= bus_src_next;
    end
  end

  // Stage 1 -> stage 2: every non-source device captures each valid beat.
  for (genvar j = 0; j < NUM_DEV; j++) begin : g_rd
    logic [WIDTH-1:0] rd_p2;

    // Per-device read-back register; the producer skips its own beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_p2 <= '0;
      end else if (vld_p1 && (bus_src_p1 != IDW'(j))) begin
        rd_p2 <= bus_p1;
      end
    end

    assign data_out[j*WIDTH +: WIDTH] = rd_p2;
  end

  assign grant     = grant_p0;
  assign bus       = bus_p1;
  assign bus_valid = vld_p1;
  assign bus_src   = bus_src_p1;

endmodule
